// File: rtl/k423_pipe_pkg.sv
// k423_pipe_pkg: shared definitions for the k423 inter-stage pipeline registers.
// Holds the occupancy width, the per-stage packed payload types and the
// payload widths derived from them. Instantiating stages set DATA_W from
// $bits() of their payload struct.
package k423_pipe_pkg;

    localparam int PIPE_OCC_W  = 2;

    // Field widths shared by the per-stage payloads.
    localparam int PIPE_XLEN   = 32;
    localparam int PIPE_REG_W  = 5;
    localparam int PIPE_ALU_W  = 4;

    // Fields carried from decode into execute.
    typedef struct packed {
        logic [PIPE_XLEN-1:0]  pc;
        logic [PIPE_XLEN-1:0]  rs1_val;
        logic [PIPE_XLEN-1:0]  rs2_val;
        logic [PIPE_REG_W-1:0] rd;
        logic [PIPE_ALU_W-1:0] alu_op;
    } id_ex_pld_t;

    // Fields carried from fetch into decode.
    typedef struct packed {
        logic [PIPE_XLEN-1:0] pc;
        logic [PIPE_XLEN-1:0] insn;
    } if_id_pld_t;

    localparam int PIPE_IF_ID_W = $bits(if_id_pld_t);
    localparam int PIPE_ID_EX_W = $bits(id_ex_pld_t);

    // Number of held entries from the two slot valid bits.
    function automatic logic [PIPE_OCC_W-1:0] occ_count(input logic main_vld,
                                                        input logic skid_vld);
        return {main_vld & skid_vld, main_vld ^ skid_vld};
    endfunction

endpackage

// File: rtl/k423_pipe_slot.sv
// k423_pipe_slot: one pipeline entry, a valid bit plus a DATA_W payload register.
// Control priority, highest first: rst_i / clr_i, ld_i, drop_i, hold.
// With CLR_DATA=1 reset and clear also zero the payload; otherwise they only
// drop the valid bit and the payload keeps its last value.
module k423_pipe_slot #(
    parameter int DATA_W   = 32,
    parameter bit CLR_DATA = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              ld_i,
    input  logic              drop_i,
    input  logic [DATA_W-1:0] d_i,
    output logic              vld_o,
    output logic [DATA_W-1:0] q_o
);

    // Valid bit: set on load, cleared on reset, clear or drop.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            vld_o <= 1'b0;
        end else if (ld_i) begin
            vld_o <= 1'b1;
        end else if (drop_i) begin
            vld_o <= 1'b0;
        end
    end

    // Payload: zeroed on reset/clear when CLR_DATA is set, captured on load.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            if (CLR_DATA) begin
                q_o <= '0;
            end
        end else if (ld_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/k423_pipe_stage.sv
// k423_pipe_stage: generic inter-stage pipeline register with valid/ready on
// both sides, flush, stall and an occupancy report.
// Build option: define K423_PIPE_SKID_EN for the two-entry skid form, whose
// in_rdy_o does not depend on out_rdy_i. Undefined gives the single-slot form.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. The producer keeps valid and data stable until it sees ready; valid
// never depends on ready. Stall and flush force in_rdy_o low and mask
// out_vld_o, so neither side transfers in those cycles.
module k423_pipe_stage
    import k423_pipe_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter bit CLR_DATA = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  stall_i,
    input  logic                  in_vld_i,
    output logic                  in_rdy_o,
    input  logic [DATA_W-1:0]     in_data_i,
    output logic                  out_vld_o,
    input  logic                  out_rdy_i,
    output logic [DATA_W-1:0]     out_data_o,
    output logic [PIPE_OCC_W-1:0] occ_o
);

    logic              hold;
    logic              in_xfer;
    logic              out_xfer;
    logic              main_vld;
    logic              main_ld;
    logic              main_drop;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] main_q;

    // Reset, flush and stall all block both handshakes for the cycle.
    assign hold       = rst_i | flush_i | stall_i;
    assign out_vld_o  = main_vld & ~hold;
    assign out_xfer   = out_vld_o & out_rdy_i;
    assign in_xfer    = in_vld_i & in_rdy_o;
    assign out_data_o = main_q;

    k423_pipe_slot #(
        .DATA_W   (DATA_W),
        .CLR_DATA (CLR_DATA)
    ) u_main (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (flush_i),
        .ld_i   (main_ld),
        .drop_i (main_drop),
        .d_i    (main_d),
        .vld_o  (main_vld),
        .q_o    (main_q)
    );

`ifdef K423_PIPE_SKID_EN

    logic              skid_vld;
    logic              skid_ld;
    logic              skid_drop;
    logic [DATA_W-1:0] skid_q;

    // Ready depends only on the registered skid valid bit and the PCU controls.
    assign in_rdy_o = ~skid_vld & ~hold;

    // Slot steering: skid refills main first, otherwise new data lands in main
    // when it is free (or being drained) and in skid when main is stuck.
    always_comb begin
        main_ld   = 1'b0;
        main_drop = 1'b0;
        main_d    = in_data_i;
        skid_ld   = 1'b0;
        skid_drop = 1'b0;
        if (out_xfer && skid_vld) begin
            main_ld   = 1'b1;
            main_d    = skid_q;
            skid_drop = 1'b1;
        end else if (in_xfer && (!main_vld || out_xfer)) begin
            main_ld   = 1'b1;
        end else if (in_xfer) begin
            skid_ld   = 1'b1;
        end else if (out_xfer) begin
            main_drop = 1'b1;
        end
    end

    k423_pipe_slot #(
        .DATA_W   (DATA_W),
        .CLR_DATA (CLR_DATA)
    ) u_skid (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (flush_i),
        .ld_i   (skid_ld),
        .drop_i (skid_drop),
        .d_i    (in_data_i),
        .vld_o  (skid_vld),
        .q_o    (skid_q)
    );

    assign occ_o = occ_count(main_vld, skid_vld);

`else

    // Ready passes combinationally from out_rdy_i when the slot is full.
    assign in_rdy_o = ~hold & (~main_vld | out_rdy_i);

    // Single slot: load on input transfer (replacing on a simultaneous drain),
    // empty on an output transfer with nothing arriving.
    always_comb begin
        main_ld   = in_xfer;
        main_drop = out_xfer & ~in_xfer;
        main_d    = in_data_i;
    end

    assign occ_o = occ_count(main_vld, 1'b0);

`endif

endmodule

// File: tb/tb_k423_pipe_stage.sv
// tb_k423_pipe_stage: self-checking bench for k423_pipe_stage.
// The reference model is a FIFO of held payloads with capacity 1 (default
// build) or 2 (K423_PIPE_SKID_EN), plus the last value handed downstream.
module tb_k423_pipe_stage;

    localparam int DATA_W = 32;
`ifdef K423_PIPE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic              clk = 1'b0;
    logic              rst_i;
    logic              flush_i;
    logic              stall_i;
    logic              in_vld_i;
    logic              in_rdy_o;
    logic [DATA_W-1:0] in_data_i;
    logic              out_vld_o;
    logic              out_rdy_i;
    logic [DATA_W-1:0] out_data_o;
    logic [1:0]        occ_o;

    int checks = 0;
    int errors = 0;

    // Model state: held entries in arrival order and last delivered payload.
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] last_out = '0;

    logic [DATA_W+3:0] act_v;
    logic [DATA_W+3:0] exp_v;

    // Clock
    always #5 clk = ~clk;

    k423_pipe_stage #(
        .DATA_W   (DATA_W),
        .CLR_DATA (1'b1)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .stall_i    (stall_i),
        .in_vld_i   (in_vld_i),
        .in_rdy_o   (in_rdy_o),
        .in_data_i  (in_data_i),
        .out_vld_o  (out_vld_o),
        .out_rdy_i  (out_rdy_i),
        .out_data_o (out_data_o),
        .occ_o      (occ_o)
    );

    // ---------------- reference model ----------------
    function automatic logic model_in_rdy();
        if (rst_i || flush_i || stall_i) return 1'b0;
        if (CAP == 2) return exp_q.size() < 2;
        return (exp_q.size() == 0) || out_rdy_i;
    endfunction

    function automatic logic model_out_vld();
        return !(rst_i || flush_i || stall_i) && (exp_q.size() > 0);
    endfunction

    function automatic logic [DATA_W+3:0] model_pack();
        logic [DATA_W-1:0] d;
        d = (exp_q.size() > 0) ? exp_q[0] : last_out;
        return {model_in_rdy(), model_out_vld(), d, 2'(exp_q.size())};
    endfunction

    // Advance model and DUT by one clock; inputs are stable across the edge.
    task automatic advance();
        logic              r;
        logic              f;
        logic              in_x;
        logic              out_x;
        logic [DATA_W-1:0] d;
        r     = rst_i;
        f     = flush_i;
        in_x  = in_vld_i && model_in_rdy();
        out_x = model_out_vld() && out_rdy_i;
        d     = in_data_i;
        @(posedge clk);
        if (r || f) begin
            exp_q.delete();
            last_out = '0;
        end else begin
            if (out_x) last_out = exp_q.pop_front();
            if (in_x) exp_q.push_back(d);
        end
        @(negedge clk);
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic r, input logic f, input logic s,
                         input logic iv, input logic [DATA_W-1:0] d,
                         input logic ordy);
        rst_i     = r;
        flush_i   = f;
        stall_i   = s;
        in_vld_i  = iv;
        in_data_i = d;
        out_rdy_i = ordy;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1, 32'hA5, 1'b1);
            #1;
            act_v = {in_rdy_o, out_vld_o, out_data_o, occ_o};
            checks++;
            if (act_v !== '0) begin
                errors++;
                $display("FAIL reset_state cycle %0d: got %h want 0", c, act_v);
            end
            advance();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        #1;
        checks++;
        if (in_rdy_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_rdy: got %b want 1", in_rdy_o);
        end
        advance();
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 5; i++) begin
            drive(1'b0, 1'b0, 1'b0, i <= 4, DATA_W'(i), 1'b1);
            #1;
            act_v = {in_rdy_o, out_vld_o, out_data_o, occ_o};
            exp_v = model_pack();
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL stream_model step %0d: got %h want %h", i, act_v, exp_v);
            end
            if (i >= 2) begin
                checks++;
                if (out_vld_o !== 1'b1 || out_data_o !== DATA_W'(i - 1) || occ_o !== 2'd1) begin
                    errors++;
                    $display("FAIL stream_out step %0d: vld=%b data=%h occ=%0d want vld=1 data=%h occ=1",
                             i, out_vld_o, out_data_o, occ_o, i - 1);
                end
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] got[$];
        logic [DATA_W-1:0] d;
        int                sent;
        sent = 0;
        for (int c = 0; c < 10; c++) begin
            d = (sent == 0) ? 32'h10 : 32'h11;
            drive(1'b0, 1'b0, 1'b0, sent < 2, d, c >= 3);
            #1;
            act_v = {in_rdy_o, out_vld_o, out_data_o, occ_o};
            exp_v = model_pack();
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL bp_model cycle %0d: got %h want %h", c, act_v, exp_v);
            end
            if (c == 2) begin
                checks++;
                if (out_vld_o !== 1'b1 || out_data_o !== 32'h10 || in_rdy_o !== 1'b0 || occ_o !== 2'(CAP)) begin
                    errors++;
                    $display("FAIL bp_full: vld=%b data=%h rdy=%b occ=%0d want vld=1 data=10 rdy=0 occ=%0d",
                             out_vld_o, out_data_o, in_rdy_o, occ_o, CAP);
                end
            end
            if (out_vld_o && out_rdy_i) got.push_back(out_data_o);
            if (in_vld_i && in_rdy_o) sent++;
            advance();
        end
        checks++;
        if (got.size() != 2 || got[0] !== 32'h10 || got[1] !== 32'h11) begin
            errors++;
            $display("FAIL bp_order: got %0d items first=%h want 2 items 10,11",
                     got.size(), (got.size() > 0) ? got[0] : '0);
        end
    endtask

    task automatic test_flush();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, DATA_W'(32'h30 + c), 1'b0);
            advance();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        #1;
        checks++;
        if (occ_o !== 2'(CAP)) begin
            errors++;
            $display("FAIL flush_prefill_occ: got %0d want %0d", occ_o, CAP);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h55, 1'b1);
        #1;
        checks++;
        if (in_rdy_o !== 1'b0 || out_vld_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_cycle_hs: rdy=%b vld=%b want 0 0", in_rdy_o, out_vld_o);
        end
        advance();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
            #1;
            checks++;
            if (occ_o !== 2'd0 || out_vld_o !== 1'b0 || out_data_o !== '0) begin
                errors++;
                $display("FAIL flush_empty cycle %0d: occ=%0d vld=%b data=%h want 0 0 0",
                         c, occ_o, out_vld_o, out_data_o);
            end
            advance();
        end
    endtask

    task automatic test_stall();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h22, 1'b0);
        advance();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h99, 1'b1);
            #1;
            checks++;
            if (out_vld_o !== 1'b0 || in_rdy_o !== 1'b0 || out_data_o !== 32'h22) begin
                errors++;
                $display("FAIL stall_hold cycle %0d: vld=%b rdy=%b data=%h want 0 0 22",
                         c, out_vld_o, in_rdy_o, out_data_o);
            end
            advance();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        #1;
        checks++;
        if (out_vld_o !== 1'b1 || out_data_o !== 32'h22) begin
            errors++;
            $display("FAIL stall_release: vld=%b data=%h want 1 22", out_vld_o, out_data_o);
        end
        advance();
        // stall and flush together: flush wins
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h44, 1'b0);
        advance();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h66, 1'b1);
        advance();
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        #1;
        checks++;
        if (occ_o !== 2'd0 || out_vld_o !== 1'b0 || out_data_o !== '0) begin
            errors++;
            $display("FAIL stall_flush_empty: occ=%0d vld=%b data=%h want 0 0 0",
                     occ_o, out_vld_o, out_data_o);
        end
        advance();
    endtask

    task automatic test_toggle();
        logic [DATA_W-1:0] sent[$];
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] want;
        logic              ordy;
        int                acc;
        int                got;
        int                cyc;
        acc  = 0;
        got  = 0;
        cyc  = 0;
        ordy = 1'b0;
        d    = $urandom();
        while ((acc < 100 || got < acc) && cyc < 600) begin
            drive(1'b0, 1'b0, 1'b0, acc < 100, d, ordy);
            #1;
            act_v = {in_rdy_o, out_vld_o, out_data_o, occ_o};
            exp_v = model_pack();
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL toggle_model cycle %0d: got %h want %h", cyc, act_v, exp_v);
            end
            if (out_vld_o && out_rdy_i) begin
                got++;
                checks++;
                if (sent.size() == 0) begin
                    errors++;
                    $display("FAIL toggle_dup: got %h want nothing pending", out_data_o);
                end else begin
                    want = sent.pop_front();
                    if (out_data_o !== want) begin
                        errors++;
                        $display("FAIL toggle_order: got %h want %h", out_data_o, want);
                    end
                end
            end
            if (in_vld_i && in_rdy_o) begin
                sent.push_back(d);
                acc++;
                d = $urandom();
            end
            advance();
            ordy = ~ordy;
            cyc++;
        end
        checks++;
        if (got != 100 || acc != 100) begin
            errors++;
            $display("FAIL toggle_count: accepted %0d delivered %0d want 100 100", acc, got);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 4,
                  $urandom_range(0, 99) < 12, $urandom_range(0, 1) == 1,
                  $urandom(), $urandom_range(0, 2) != 0);
            #1;
            act_v = {in_rdy_o, out_vld_o, out_data_o, occ_o};
            exp_v = model_pack();
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL random_model cycle %0d: got %h want %h", c, act_v, exp_v);
            end
            advance();
        end
    endtask

    // Reset, sequence the scenarios, report.
    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'hA5, 1'b1);
        @(posedge clk);
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_stall();
        test_toggle();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/k423_pipe_stage.md
# k423_pipe_stage

Generic, parametrised inter-stage pipeline register for the k423 core. It replaces the hand-written per-stage registers (if/id, id/ex, ex/mem, mem/wb) with one block that carries an opaque payload of `DATA_W` bits. It adds a full valid/ready handshake on both sides, an upstream ready output, optional skid buffering, flush-with-clear, stall, and an occupancy report. Each instance sits between two stages; the stage-specific payload is packed and unpacked by the instantiating stage.

## Interface
Parameters:
- `DATA_W`, default 32: payload width in bits; legal range ≥1.
- `CLR_DATA`, default 1: 1 means flush and reset zero the payload registers; 0 means flush and reset clear only the valid bits.

Ports:
- `clk_i`, in, 1: clock, rising edge.
- `rst_i`, in, 1: reset; synchronous, active-high.
- `flush_i`, in, 1: pipeline clear (PCU); drop all held entries.
- `stall_i`, in, 1: pipeline hold (PCU); freeze contents.
- `in_vld_i`, in, 1: upstream payload valid.
- `in_rdy_o`, out, 1: this block can accept a payload.
- `in_data_i`, in, `DATA_W`: upstream payload.
- `out_vld_o`, out, 1: downstream payload valid.
- `out_rdy_i`, in, 1: downstream stage ready.
- `out_data_o`, out, `DATA_W`: payload to downstream.
- `occ_o`, out, 2: number of held entries (0–2).

## Operation
- Input transfer occurs when `in_vld_i & in_rdy_o`. Output transfer occurs when `out_vld_o & out_rdy_i`.
- Priority, highest first: `rst_i`, `flush_i`, `stall_i`, normal handshake.
- `flush_i`:
  - Next cycle, all entries are invalid and `occ_o` is 0.
  - A payload offered in the flush cycle is dropped.
  - If `CLR_DATA`=1, the payload registers are zeroed.
  - `in_rdy_o` and `out_vld_o` behave as for stall during the flush cycle, so no transfer occurs.
- `stall_i` (without flush):
  - `in_rdy_o` is forced to 0 and `out_vld_o` is masked to 0.
  - All internal state, including `out_data_o`, holds.
- Normal operation:
  - `out_data_o` is always driven from the main slot.
  - `out_vld_o` equals the main-slot valid bit.
- The payload is passed through unmodified; the block adds no arithmetic.
- Entries leave in arrival order. There is no duplication and no loss except on flush.

## Timing
- Reset: `out_vld_o`=0, `occ_o`=0, `in_rdy_o`=0 while `rst_i` is high, and `out_data_o`=0 when `CLR_DATA`=1.
- Latency: 1 cycle from input transfer to `out_vld_o`. Throughput: 1 transfer per cycle when downstream never backpressures.
- Without skid (single main slot):
  - `in_rdy_o = ~stall_i & ~flush_i & (~main_vld | out_rdy_i)`; this is a combinational path from `out_rdy_i`.
  - Simultaneous input and output transfer on a full slot replaces the contents; `occ_o` stays 1.
- With skid (main slot plus skid slot):
  - `in_rdy_o = ~skid_vld & ~stall_i & ~flush_i`; it has no dependency on `out_rdy_i`.
  - Input transfer while main is valid and there is no output transfer: the payload goes to the skid slot and `occ_o` becomes 2.
  - Output transfer while skid is valid: the skid payload moves to main next cycle, and skid becomes invalid.
  - Input transfer with main empty: the payload goes to main.
  - Input transfer with main full and an output transfer in the same cycle: the payload goes to main.
- Boundary conditions:
  - When full (`occ_o`=2), `in_rdy_o`=0.
  - When empty, `out_vld_o`=0 and `out_data_o` keeps its last value, or 0 after flush if `CLR_DATA`=1.
  - `rst_i` asserted mid-transfer overrides everything; the next cycle equals the reset state.

## Configuration
- `K423_PIPE_SKID_EN` defined: the two-entry skid form; `in_rdy_o` is a registered signal, which breaks the ready timing path across stages. `occ_o` ranges 0–2.
- `K423_PIPE_SKID_EN` undefined: the single-slot form; the skid slot is not instantiated and `occ_o[1]` is tied to 0.
- In both forms the port list is identical.

## Structure
- Add to `k423_defines.svh`: `PIPE_OCC_W` = 2, and the per-stage payload widths (e.g. `PIPE_ID_EX_W`), each derived from the existing field widths.
- Each stage packs its fields into a packed struct defined in a shared package `k423_pipe_pkg`, for example `id_ex_pld_t`; `DATA_W` is set to `$bits(id_ex_pld_t)`.
- Sub-module `k423_pipe_slot`: one valid bit plus a `DATA_W` register with load, clear (honouring `CLR_DATA`) and hold controls. It is instantiated once, or twice with `K423_PIPE_SKID_EN`.

## Test plan
- Reset:
  - Stimulus: `rst_i`=1 for 2 cycles with `in_vld_i`=1 and `in_data_i`=0xA5.
  - Required response: `out_vld_o`=0, `in_rdy_o`=0, `occ_o`=0 and `out_data_o`=0 throughout; one cycle after release, `in_rdy_o`=1.
- Streaming:
  - Stimulus: `out_rdy_i`=1; values 1, 2, 3, 4 offered on consecutive cycles.
  - Required response: the same values appear on `out_data_o` one cycle later with `out_vld_o`=1 each cycle; `occ_o`=1 throughout.
- Backpressure (skid form):
  - Stimulus: `out_rdy_i`=0 while 0x10 and 0x11 are offered.
  - Required response: 0x10 is held on the output, `occ_o`=2, `in_rdy_o`=0; after `out_rdy_i` rises, 0x10 then 0x11 are delivered in order.
- Flush:
  - Stimulus: with `occ_o`=2, assert `flush_i` together with `in_vld_i`=1 and `in_data_i`=0x55.
  - Required response: next cycle `occ_o`=0, `out_vld_o`=0, `out_data_o`=0 (`CLR_DATA`=1), and 0x55 is never delivered.
- Stall and flush priority:
  - Stimulus 1: assert `stall_i` for 3 cycles with 0x22 held.
  - Required response 1: `out_vld_o`=0, `in_rdy_o`=0 and `out_data_o`=0x22 throughout; 0x22 is delivered after release.
  - Stimulus 2: `stall_i` and `flush_i` asserted together.
  - Required response 2: the block is emptied.
- Single-slot form:
  - Stimulus: `out_rdy_i` toggles every cycle while `in_vld_i`=1.
  - Required response: `in_rdy_o` tracks `(~main_vld | out_rdy_i)` in the same cycle; there is no loss or duplication over 100 random payloads, checked with a scoreboard.
